// File: rtl/rgmii_rx_decoder_pkg.sv
// Shared definitions for the RGMII receive decoder and its transmit-side sibling.
// Contents:
//   rx_state_t      frame-recovery FSM states
//   PREAMBLE, SFD   Ethernet preamble and start-of-frame-delimiter octets
//   SPEED_*         in-band link speed codes
//   link_status_t   decoded in-band status nibble
//   decode_status   nibble -> link_status_t
package rgmii_rx_decoder_pkg;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,  // waiting for a gap so a frame already in progress is not picked up
    ST_IDLE = 3'd1,  // inter-frame gap, looking for preamble or SFD
    ST_PRE  = 3'd2,  // inside the preamble
    ST_PAY  = 3'd3,  // emitting payload + FCS bytes
    ST_DROP = 3'd4   // discarding the remainder of a frame until the gap
  } rx_state_t;

  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  typedef struct packed {
    logic       duplex;
    logic [1:0] speed;
    logic       up;
  } link_status_t;

  // In-band status nibble layout: [3]=duplex, [2:1]=speed, [0]=link up.
  function automatic link_status_t decode_status(input logic [3:0] nib);
    link_status_t st;
    st.up     = nib[0];
    st.speed  = nib[2:1];
    st.duplex = nib[3];
    return st;
  endfunction

endpackage

// File: rtl/rgmii_rx_decoder_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Ports:
//   clock  in   1      counter clock
//   reset  in   1      asynchronous, active-high, clears the count
//   inc    in   1      add one this cycle (ignored once saturated)
//   count  out  WIDTH  current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decoder. Rebuilds bytes from the DDR capture stage, strips
// preamble/SFD, emits payload+FCS as a stream with last/bad flags, decodes
// in-band link status from the inter-frame gap and counts good/bad frames.
// Ports:
//   clock        in   1          RGMII rx clock (same as capture stage)
//   reset        in   1          asynchronous, active-high
//   rx_q1        in   5          rising-edge half  {RX_DV,  rxd = byte[3:0]}
//   rx_q2        in   5          falling-edge half {DV^ER,  rxd = byte[7:4]}
//   m_tdata      out  8          payload byte
//   m_tvalid     out  1          byte valid, no backpressure
//   m_tlast      out  1          last byte of frame
//   m_tuser      out  1          frame bad, qualified by m_tlast
//   link_up      out  1          in-band status bit 0
//   link_speed   out  2          in-band status bits [2:1]
//   link_duplex  out  1          in-band status bit 3
//   frame_count  out  CNT_WIDTH  good frames, saturating
//   error_count  out  CNT_WIDTH  bad/aborted/dropped frames, saturating
import rgmii_rx_decoder_pkg::*;

module rgmii_rx_decoder #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           rx_q1,
  input  logic [4:0]           rx_q2,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic                 m_tuser,
  output logic                 link_up,
  output logic [1:0]           link_speed,
  output logic                 link_duplex,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  // Frame lengths are tracked in 16 bits; MAX_FRAME_LEN must stay below 65536.
  localparam int LEN_W = 16;

  // Raw per-cycle decode of the capture stage.
  logic [7:0] in_byte;
  logic       in_dv;
  logic       in_er;

  assign in_byte = {rx_q2[3:0], rx_q1[3:0]};
  assign in_dv   = rx_q1[4];
  assign in_er   = rx_q1[4] ^ rx_q2[4];

  // Stage s1: the byte the FSM is deciding about this cycle.
  logic [7:0] s1_byte_reg;
  logic       s1_dv_reg;
  logic       s1_er_reg;
  // Cleared by reset so the reset value of s1 is never mistaken for a real
  // gap byte; otherwise SYNC could leave on a fake dv=0 while a frame runs.
  logic       s1_valid_reg;

  rx_state_t        state_reg;
  logic [LEN_W-1:0] len_reg;
  logic             bad_reg;
  logic             frame_inc_reg;
  logic             error_inc_reg;

  // Per-beat decisions for the s1 byte when it is a payload byte. The byte
  // now at the inputs is the one that follows it, so its dv decides tlast.
  logic [LEN_W-1:0] len_next;
  logic             at_max;
  logic             beat_last;
  logic             beat_bad;

  assign len_next  = len_reg + LEN_W'(1);
  assign at_max    = (len_next == LEN_W'(MAX_FRAME_LEN));
  assign beat_last = !in_dv || at_max;
  assign beat_bad  = bad_reg || s1_er_reg
                  || (len_next < LEN_W'(MIN_FRAME_LEN))
                  || (at_max && in_dv);

  // A gap byte carries link status only when it is clean (no carrier event)
  // and both nibbles agree, which filters out glitches on a single edge.
  logic         status_ok;
  link_status_t s1_status;

  assign status_ok = s1_valid_reg && !s1_dv_reg && !s1_er_reg
                  && (s1_byte_reg[7:4] == s1_byte_reg[3:0]);
  assign s1_status = decode_status(s1_byte_reg[3:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_byte_reg   <= '0;
      s1_dv_reg     <= 1'b0;
      s1_er_reg     <= 1'b0;
      s1_valid_reg  <= 1'b0;
      state_reg     <= ST_SYNC;
      len_reg       <= '0;
      bad_reg       <= 1'b0;
      frame_inc_reg <= 1'b0;
      error_inc_reg <= 1'b0;
      m_tdata       <= '0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      m_tuser       <= 1'b0;
      link_up       <= 1'b0;
      link_speed    <= '0;
      link_duplex   <= 1'b0;
    end else begin
      s1_byte_reg  <= in_byte;
      s1_dv_reg    <= in_dv;
      s1_er_reg    <= in_er;
      s1_valid_reg <= 1'b1;

      m_tdata       <= '0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      m_tuser       <= 1'b0;
      frame_inc_reg <= 1'b0;
      error_inc_reg <= 1'b0;

      if (status_ok) begin
        link_up     <= s1_status.up;
        link_speed  <= s1_status.speed;
        link_duplex <= s1_status.duplex;
      end

      case (state_reg)
        ST_SYNC: begin
          if (s1_valid_reg && !s1_dv_reg) begin
            state_reg <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (s1_dv_reg) begin
            len_reg <= '0;
            bad_reg <= s1_er_reg;
            if (s1_byte_reg == PREAMBLE) begin
              state_reg <= ST_PRE;
            end else if (s1_byte_reg == SFD) begin
              state_reg <= ST_PAY;
            end else begin
              state_reg <= ST_DROP;
            end
          end
        end

        ST_PRE: begin
          if (!s1_dv_reg) begin
            // Carrier ended before any SFD.
            error_inc_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            bad_reg <= bad_reg | s1_er_reg;
            if (s1_byte_reg == SFD) begin
              state_reg <= ST_PAY;
            end else if (s1_byte_reg != PREAMBLE) begin
              state_reg <= ST_DROP;
            end
          end
        end

        ST_PAY: begin
          if (!s1_dv_reg) begin
            // Only reachable straight after the SFD: a zero-byte frame.
            error_inc_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            m_tvalid <= 1'b1;
            m_tdata  <= s1_byte_reg;
            len_reg  <= len_next;
            bad_reg  <= bad_reg | s1_er_reg;
            if (beat_last) begin
              m_tlast       <= 1'b1;
              m_tuser       <= beat_bad;
              frame_inc_reg <= !beat_bad;
              error_inc_reg <= beat_bad;
              // Carrier still up means the frame was cut at MAX_FRAME_LEN.
              state_reg     <= in_dv ? ST_DROP : ST_IDLE;
            end
          end
        end

        ST_DROP: begin
          if (!s1_dv_reg) begin
            error_inc_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_SYNC;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_frame_counter (
    .clock (clock),
    .reset (reset),
    .inc   (frame_inc_reg),
    .count (frame_count)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_error_counter (
    .clock (clock),
    .reset (reset),
    .inc   (error_inc_reg),
    .count (error_count)
  );

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Self-checking bench for rgmii_rx_decoder. Frames are built as byte/er lists,
// a frame-level reference model derives the expected beats, counters and link
// status, and a negedge monitor collects what the DUT emits.
module tb_rgmii_rx_decoder;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 100;
  localparam int CW      = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    rx_q1;
  logic [4:0]    rx_q2;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tuser;
  logic          link_up;
  logic [1:0]    link_speed;
  logic          link_duplex;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] error_count;

  rgmii_rx_decoder #(
    .MIN_FRAME_LEN (MIN_LEN),
    .MAX_FRAME_LEN (MAX_LEN),
    .CNT_WIDTH     (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_q1       (rx_q1),
    .rx_q2       (rx_q2),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex),
    .frame_count (frame_count),
    .error_count (error_count)
  );

  always #4 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  int    tests = 0;
  int    fails = 0;
  int    edge_cnt = 0;
  beat_t got_q[$];
  int    got_edge_q[$];
  beat_t exp_q[$];
  int    exp_frames;
  int    exp_errors;
  logic [3:0] exp_nib;
  logic [7:0] tx_bytes[$];
  bit         tx_er[$];
  int         pay_idx;
  int         pay_edge;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin
    if (m_tvalid) begin
      got_q.push_back(beat_t'({m_tdata, m_tlast, m_tuser}));
      got_edge_q.push_back(edge_cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [CW-1:0] sat(input int v);
    return (v > 15) ? 4'hF : CW'(v);
  endfunction

  // One RGMII cycle: dv on the rising half, dv^er on the falling half.
  task automatic drive(input bit dv, input bit er, input logic [7:0] b);
    rx_q1 = {dv, b[3:0]};
    rx_q2 = {dv ^ er, b[7:4]};
    @(posedge clock);
    #1;
  endtask

  task automatic gap(input int n, input bit er, input logic [7:0] b);
    repeat (n) drive(1'b0, er, b);
    if (!er && (b[7:4] == b[3:0])) exp_nib = b[3:0];
  endtask

  task automatic build_frame(input int pre_len, input int pay_len, input bit garbage,
                             input bit rand_data);
    logic [7:0] g;
    tx_bytes.delete();
    tx_er.delete();
    pay_idx = -1;
    if (garbage) begin
      do g = 8'($urandom); while (g == 8'h55 || g == 8'hD5);
      tx_bytes.push_back(g);
    end else begin
      repeat (pre_len) tx_bytes.push_back(8'h55);
      tx_bytes.push_back(8'hD5);
      pay_idx = pre_len + 1;
    end
    for (int k = 0; k < pay_len; k++)
      tx_bytes.push_back(rand_data ? 8'($urandom) : 8'(k));
    foreach (tx_bytes[k]) tx_er.push_back(1'b0);
  endtask

  task automatic send_frame();
    for (int k = 0; k < tx_bytes.size(); k++) begin
      if (k == pay_idx) pay_edge = edge_cnt;
      drive(1'b1, tx_er[k], tx_bytes[k]);
    end
  endtask

  // Frame-level reference: find SFD after any 0x55 run, emit up to MAX_LEN
  // payload bytes, mark bad on er/short/truncated, and account the counters.
  task automatic model_frame();
    int    i;
    int    n;
    int    sfd;
    int    plen;
    int    emit;
    bit    bad;
    bit    user;
    beat_t b;
    n = tx_bytes.size();
    i = 0;
    while (i < n && tx_bytes[i] == 8'h55) i++;
    if (i >= n || tx_bytes[i] != 8'hD5) begin
      exp_errors++;
      return;
    end
    sfd  = i;
    plen = n - sfd - 1;
    if (plen == 0) begin
      exp_errors++;
      return;
    end
    emit = (plen > MAX_LEN) ? MAX_LEN : plen;
    bad  = 1'b0;
    for (int k = 0; k <= sfd + emit; k++) bad |= tx_er[k];
    user = bad || (emit < MIN_LEN) || (plen > MAX_LEN);
    for (int k = 0; k < emit; k++) begin
      b.data = tx_bytes[sfd + 1 + k];
      b.last = (k == emit - 1);
      b.user = b.last & user;
      exp_q.push_back(b);
    end
    if (user) exp_errors++;
    else exp_frames++;
    if (plen > MAX_LEN) exp_errors++;
  endtask

  task automatic test_reset();
    exp_frames = 0;
    exp_errors = 0;
    exp_nib    = 4'h0;
    reset = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 8'($urandom));
    tests++;
    if ({m_tdata, m_tvalid, m_tlast, m_tuser, link_up, link_speed, link_duplex,
         frame_count, error_count} !== '0) begin
      fails++;
      $display("FAIL reset_held: outputs tdata=%h v=%b l=%b u=%b fc=%0d ec=%0d, required all 0",
               m_tdata, m_tvalid, m_tlast, m_tuser, frame_count, error_count);
    end
    rx_q1 = 5'd0;
    rx_q2 = 5'd0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    tests++;
    if ({m_tdata, m_tvalid, m_tlast, m_tuser, link_up, link_speed, link_duplex,
         frame_count, error_count} !== '0) begin
      fails++;
      $display("FAIL reset_release: outputs tdata=%h v=%b l=%b u=%b fc=%0d ec=%0d, required all 0",
               m_tdata, m_tvalid, m_tlast, m_tuser, frame_count, error_count);
    end
    gap(3, 1'b0, 8'h00);
    got_q.delete();
    got_edge_q.delete();
  endtask

  task automatic test_basic();
    build_frame(7, 64, 1'b0, 1'b0);
    model_frame();
    send_frame();
    gap(4, 1'b0, 8'h00);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL basic_beats: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL basic_beat[%0d]: got %h/%b/%b, required %h/%b/%b", k,
                 got_q[k].data, got_q[k].last, got_q[k].user,
                 exp_q[k].data, exp_q[k].last, exp_q[k].user);
      end
    end
    tests++;
    if (got_edge_q.size() == 0 || got_edge_q[0] - pay_edge != 2) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles, required 2",
               (got_edge_q.size() == 0) ? -1 : got_edge_q[0] - pay_edge);
    end
    tests++;
    if (frame_count !== 4'd1 || error_count !== sat(exp_errors)) begin
      fails++;
      $display("FAIL basic_counts: got fc=%0d ec=%0d, required fc=1 ec=%0d",
               frame_count, error_count, sat(exp_errors));
    end
    got_q.delete(); got_edge_q.delete(); exp_q.delete();
  endtask

  task automatic test_er_frame();
    build_frame(7, 64, 1'b0, 1'b0);
    tx_er[8 + 10] = 1'b1;
    model_frame();
    send_frame();
    gap(4, 1'b0, 8'h00);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL er_beats: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL er_beat[%0d]: got %h/%b/%b, required %h/%b/%b", k,
                 got_q[k].data, got_q[k].last, got_q[k].user,
                 exp_q[k].data, exp_q[k].last, exp_q[k].user);
      end
    end
    tests++;
    if (frame_count !== 4'd1 || error_count !== 4'd1) begin
      fails++;
      $display("FAIL er_counts: got fc=%0d ec=%0d, required fc=1 ec=1", frame_count, error_count);
    end
    got_q.delete(); got_edge_q.delete(); exp_q.delete();
  endtask

  task automatic test_truncation();
    build_frame(7, 150, 1'b0, 1'b1);
    model_frame();
    send_frame();
    gap(4, 1'b0, 8'h00);
    tests++;
    if (got_q.size() != MAX_LEN) begin
      fails++;
      $display("FAIL trunc_beats: got %0d beats, required %0d", got_q.size(), MAX_LEN);
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL trunc_beat[%0d]: got %h/%b/%b, required %h/%b/%b", k,
                 got_q[k].data, got_q[k].last, got_q[k].user,
                 exp_q[k].data, exp_q[k].last, exp_q[k].user);
      end
    end
    tests++;
    if (frame_count !== 4'd1 || error_count !== 4'd3) begin
      fails++;
      $display("FAIL trunc_counts: got fc=%0d ec=%0d, required fc=1 ec=3", frame_count, error_count);
    end
    got_q.delete(); got_edge_q.delete(); exp_q.delete();
  endtask

  task automatic test_link_status();
    gap(3, 1'b0, 8'hDD);
    tests++;
    if (link_up !== 1'b1 || link_speed !== 2'b10 || link_duplex !== 1'b1) begin
      fails++;
      $display("FAIL status_dd: got up=%b speed=%b dup=%b, required up=1 speed=10 dup=1",
               link_up, link_speed, link_duplex);
    end
    gap(3, 1'b0, 8'h1D);
    tests++;
    if ({link_duplex, link_speed, link_up} !== 4'hD) begin
      fails++;
      $display("FAIL status_mismatch_hold: got %h, required d", {link_duplex, link_speed, link_up});
    end
    gap(3, 1'b1, 8'h22);
    tests++;
    if ({link_duplex, link_speed, link_up} !== 4'hD) begin
      fails++;
      $display("FAIL status_carrier_hold: got %h, required d", {link_duplex, link_speed, link_up});
    end
    gap(3, 1'b0, 8'h66);
    tests++;
    if (link_up !== 1'b0 || link_speed !== 2'b11 || link_duplex !== 1'b0) begin
      fails++;
      $display("FAIL status_66: got up=%b speed=%b dup=%b, required up=0 speed=11 dup=0",
               link_up, link_speed, link_duplex);
    end
    tests++;
    if (frame_count !== sat(exp_frames) || error_count !== sat(exp_errors)) begin
      fails++;
      $display("FAIL status_counts: got fc=%0d ec=%0d, required fc=%0d ec=%0d",
               frame_count, error_count, sat(exp_frames), sat(exp_errors));
    end
  endtask

  task automatic test_midframe_reset();
    build_frame(7, 80, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, tx_bytes[k]);
    reset = 1'b1;
    got_q.delete(); got_edge_q.delete(); exp_q.delete();
    exp_frames = 0;
    exp_errors = 0;
    exp_nib    = 4'h0;
    for (int k = 20; k < 23; k++) drive(1'b1, 1'b0, tx_bytes[k]);
    reset = 1'b0;
    // Carrier continues with bytes that look like a fresh preamble + SFD.
    repeat (5) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int k = 23; k < tx_bytes.size(); k++) drive(1'b1, 1'b0, tx_bytes[k]);
    gap(4, 1'b0, 8'hDD);
    tests++;
    if (got_q.size() != 0 || frame_count !== 4'd0 || error_count !== 4'd0) begin
      fails++;
      $display("FAIL midreset_partial: got %0d beats fc=%0d ec=%0d, required 0 beats fc=0 ec=0",
               got_q.size(), frame_count, error_count);
    end
    build_frame(3, 70, 1'b0, 1'b1);
    model_frame();
    send_frame();
    gap(4, 1'b0, 8'hDD);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL midreset_next_beats: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL midreset_beat[%0d]: got %h/%b/%b, required %h/%b/%b", k,
                 got_q[k].data, got_q[k].last, got_q[k].user,
                 exp_q[k].data, exp_q[k].last, exp_q[k].user);
      end
    end
    tests++;
    if (frame_count !== 4'd1 || error_count !== 4'd0 || {link_duplex, link_speed, link_up} !== exp_nib) begin
      fails++;
      $display("FAIL midreset_next_counts: got fc=%0d ec=%0d st=%h, required fc=1 ec=0 st=%h",
               frame_count, error_count, {link_duplex, link_speed, link_up}, exp_nib);
    end
    got_q.delete(); got_edge_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int len_tab[10] = '{0, 1, 10, 63, 64, 65, 99, 100, 101, 130};
    int plen;
    int kind;
    logic [7:0] gb;
    for (int f = 0; f < 16; f++) begin
      plen = ($urandom_range(0, 1) == 0) ? len_tab[$urandom_range(0, 9)] : int'($urandom_range(1, 120));
      build_frame(int'($urandom_range(0, 7)), plen, ($urandom_range(0, 7) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) tx_er[$urandom_range(0, tx_bytes.size() - 1)] = 1'b1;
      model_frame();
      send_frame();
      kind = int'($urandom_range(0, 2));
      gb   = 8'($urandom);
      if (kind == 0) gb[7:4] = gb[3:0];
      gap(int'($urandom_range(3, 5)), (kind == 2), gb);
      tests++;
      if (got_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL rand%0d_beats: got %0d beats, required %0d", f, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        tests++;
        if (got_q[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL rand%0d_beat[%0d]: got %h/%b/%b, required %h/%b/%b", f, k,
                   got_q[k].data, got_q[k].last, got_q[k].user,
                   exp_q[k].data, exp_q[k].last, exp_q[k].user);
        end
      end
      tests++;
      if (frame_count !== sat(exp_frames) || error_count !== sat(exp_errors)
          || {link_duplex, link_speed, link_up} !== exp_nib) begin
        fails++;
        $display("FAIL rand%0d_state: got fc=%0d ec=%0d st=%h, required fc=%0d ec=%0d st=%h", f,
                 frame_count, error_count, {link_duplex, link_speed, link_up},
                 sat(exp_frames), sat(exp_errors), exp_nib);
      end
      $display("[TB] random frame %0d: len %0d, %0d beats", f, plen, got_q.size());
      got_q.delete(); got_edge_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 20; f++) begin
      build_frame(7, 64, 1'b0, 1'b1);
      model_frame();
      send_frame();
      gap(3, 1'b0, 8'h00);
      tests++;
      if (got_q.size() != exp_q.size() || frame_count !== sat(exp_frames)
          || error_count !== sat(exp_errors)) begin
        fails++;
        $display("FAIL sat%0d: got %0d beats fc=%0d ec=%0d, required %0d beats fc=%0d ec=%0d", f,
                 got_q.size(), frame_count, error_count, exp_q.size(),
                 sat(exp_frames), sat(exp_errors));
      end
      got_q.delete(); got_edge_q.delete(); exp_q.delete();
    end
    tests++;
    if (frame_count !== 4'hF) begin
      fails++;
      $display("FAIL sat_final: got fc=%0d, required 15", frame_count);
    end
  endtask

  initial begin
    rx_q1 = 5'd0;
    rx_q2 = 5'd0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_er_frame();
    test_truncation();
    test_link_status();
    test_midframe_reset();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
